i2c_slave_bit_controller: RTL

Byte-level protocol sequencer for the I2C slave. It consumes the filtered SCL/SDA levels and single-cycle edge pulses produced by the two per-line edge filters. It detects START, repeated START and STOP, and matches the 7-bit address. It shifts write bytes in and read bytes out, and drives the SDA pull-down for ACK and read data. It sits between the edge filters and the register/LCD/button front end, which sees only byte-wide handshakes.

---
 rtl/i2c_slave_bit_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_bit_controller.sv
// I2C slave byte sequencer: START/STOP detection, address match, byte shift in/out, ACK drive.
// Optional macro I2C_SLAVE_GENCALL_EN makes the general-call address (7'h00, write) match as well.
module i2c_slave_bit_controller #(
   parameter logic [6:0] SLAVE_ADDR = 7'h27
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_f,
   input  logic       sda_f,
   input  logic       scl_pe,
   input  logic       scl_ne,
   input  logic       sda_pe,
   input  logic       sda_ne,
   input  logic [7:0] tx_data,
   output logic       sda_drive,
   output logic       busy,
   output logic       start_det,
   output logic       stop_det,
   output logic       addr_hit,
   output logic       rw,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       nack_rx
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_ADDR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
   } state_t;

   state_t     r_state;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_pend;

   logic       w_cond;
   logic       w_start;
   logic       w_stop;
   logic       w_last;
   logic       w_gc;
   logic       w_match;
   logic [7:0] w_shift_in;

   assign w_cond     = scl_f & ~scl_ne;
   assign w_start    = w_cond & sda_ne;
   assign w_stop     = w_cond & sda_pe;
   assign w_shift_in = {r_shift[6:0], sda_f};
   assign w_last     = (r_bit_cnt == 3'd7);

`ifdef I2C_SLAVE_GENCALL_EN
   assign w_gc = (w_shift_in == 8'h00);
`else
   assign w_gc = 1'b0;
`endif

   assign w_match = (w_shift_in[7:1] == SLAVE_ADDR) | w_gc;

   // r_pend marks "byte finished, act on the next SCL falling edge"
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
         r_pend    <= 1'b0;
         sda_drive <= 1'b0;
         busy      <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         addr_hit  <= 1'b0;
         rw        <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         nack_rx   <= 1'b0;
      end else begin
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         addr_hit  <= 1'b0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         nack_rx   <= 1'b0;
         if (w_start) begin
            start_det <= 1'b1;
            busy      <= 1'b1;
            r_state   <= ADDR;
            r_bit_cnt <= 3'd0;
            r_pend    <= 1'b0;
            sda_drive <= 1'b0;
         end else if (w_stop) begin
            stop_det  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
            r_pend    <= 1'b0;
            sda_drive <= 1'b0;
         end else begin
            case (r_state)
               ADDR: begin
                  if (scl_pe && !r_pend) begin
                     r_shift   <= w_shift_in;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_last) begin
                        if (w_match) begin
                           addr_hit <= 1'b1;
                           rw       <= w_shift_in[0];
                           tx_req   <= w_shift_in[0];
                           r_pend   <= 1'b1;
                        end else begin
                           sda_drive <= 1'b0;
                           r_state   <= WAIT_STOP;
                        end
                     end
                  end else if (scl_ne && r_pend) begin
                     r_pend    <= 1'b0;
                     sda_drive <= 1'b1;
                     r_state   <= ACK_ADDR;
                  end
               end
               ACK_ADDR: begin
                  if (scl_ne) begin
                     if (rw) begin
                        r_shift   <= tx_data;
                        sda_drive <= ~tx_data[7];
                        r_state   <= RD_DATA;
                     end else begin
                        sda_drive <= 1'b0;
                        r_state   <= WR_DATA;
                     end
                  end
               end
               WR_DATA: begin
                  if (scl_pe && !r_pend) begin
                     r_shift   <= w_shift_in;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_last) begin
                        rx_data  <= w_shift_in;
                        rx_valid <= 1'b1;
                        r_pend   <= 1'b1;
                     end
                  end else if (scl_ne && r_pend) begin
                     r_pend    <= 1'b0;
                     sda_drive <= 1'b1;
                     r_state   <= WR_ACK;
                  end
               end
               WR_ACK: begin
                  if (scl_ne) begin
                     sda_drive <= 1'b0;
                     r_state   <= WR_DATA;
                  end
               end
               RD_DATA: begin
                  if (scl_pe && !r_pend) begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_last) r_pend <= 1'b1;
                  end else if (scl_ne) begin
                     if (r_pend) begin
                        r_pend    <= 1'b0;
                        sda_drive <= 1'b0;
                        r_state   <= RD_ACK;
                     end else begin
                        r_shift   <= {r_shift[6:0], 1'b0};
                        sda_drive <= ~r_shift[6];
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_pe && !r_pend) begin
                     if (!sda_f) begin
                        tx_req <= 1'b1;
                        r_pend <= 1'b1;
                     end else begin
                        nack_rx   <= 1'b1;
                        sda_drive <= 1'b0;
                        r_state   <= WAIT_STOP;
                     end
                  end else if (scl_ne && r_pend) begin
                     r_pend    <= 1'b0;
                     r_shift   <= tx_data;
                     sda_drive <= ~tx_data[7];
                     r_state   <= RD_DATA;
                  end
               end
               IDLE, WAIT_STOP: begin
                  sda_drive <= 1'b0;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
